// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end.
// Owns the fetch PC, issues one-at-a-time irom reads, buffers returned words
// in a small FIFO and hands them to decode over a valid/ready handshake.
// Branch redirects flush the FIFO and drop any in-flight response.
// Optional halt-on-opcode support is enabled by defining IFETCH_HALT_EN.
module ifetch_queue #(
  parameter int                 DWIDTH   = 16,
  parameter int                 AWIDTH   = 12,
  parameter int                 DEPTH    = 4,
  parameter logic [AWIDTH-1:0]  RESET_PC = '0,
  parameter logic [DWIDTH-1:0]  HALT_OP  = 16'hF000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  output logic              rom_ready,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic              rom_valid,
  input  logic [DWIDTH-1:0] rom_data,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [DWIDTH-1:0] ins,
  output logic [AWIDTH-1:0] ins_pc,
  output logic              halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

`ifdef IFETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  logic [1:0]        state_r, state_nx_s;
  logic              drop_r, drop_nx_s;
  logic [AWIDTH-1:0] pc_r;
  logic [CW-1:0]     count_r, count_nx_s, count_base_s;
  logic [PW-1:0]     rd_ptr_r, wr_ptr_r;
  logic [DWIDTH-1:0] data_mem_r [DEPTH];
  logic [AWIDTH-1:0] pc_mem_r   [DEPTH];
  logic              halted_r;

  logic rsp_s, push_s, pop_s, halt_hit_s, halt_block_s, issue_ok_s;

  // A response only counts while waiting; it is enqueued unless stale or
  // overridden by a redirect in the same cycle.
  assign rsp_s        = (state_r == ST_WAIT) && rom_valid;
  assign push_s       = rsp_s && !drop_r && !redirect;
  assign pop_s        = ins_valid && ins_ready && !redirect;
  assign halt_hit_s   = HALT_EN && push_s && (rom_data == HALT_OP);
  assign halt_block_s = redirect ? 1'b0 : (halted_r || halt_hit_s);
  // Occupancy seen by the next request: the word arriving now already owns
  // its slot, a redirect empties the queue. Pops are not credited.
  assign count_base_s = redirect ? '0 : (count_r + {{PW{1'b0}}, push_s});
  assign issue_ok_s   = en_in && !halt_block_s && (count_base_s < DEPTH_C);

  assign rom_ready = (state_r == ST_REQ);
  assign rom_addr  = pc_r;
  assign ins_valid = (count_r != '0);
  assign ins       = data_mem_r[rd_ptr_r];
  assign ins_pc    = pc_mem_r[rd_ptr_r];
  assign halted    = halted_r;

  // Fetch FSM next state and stale-response flag.
  always_comb begin
    state_nx_s = state_r;
    drop_nx_s  = drop_r;
    case (state_r)
      ST_IDLE: begin
        if (issue_ok_s) state_nx_s = ST_REQ;
        else            state_nx_s = ST_IDLE;
      end
      ST_REQ: begin
        state_nx_s = ST_WAIT;
        drop_nx_s  = redirect;
      end
      ST_WAIT: begin
        if (rsp_s) begin
          drop_nx_s = 1'b0;
          if (issue_ok_s) state_nx_s = ST_REQ;
          else            state_nx_s = ST_IDLE;
        end else if (redirect) begin
          drop_nx_s  = 1'b1;
          state_nx_s = ST_WAIT;
        end else begin
          drop_nx_s  = drop_r;
          state_nx_s = ST_WAIT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        drop_nx_s  = 1'b0;
      end
    endcase
  end

  // FIFO occupancy after this cycle's flush, push and pop.
  always_comb begin
    count_nx_s = count_r;
    if (redirect)              count_nx_s = '0;
    else if (push_s && !pop_s) count_nx_s = count_r + CW'(1);
    else if (!push_s && pop_s) count_nx_s = count_r - CW'(1);
    else                       count_nx_s = count_r;
  end

  // FSM, PC and halt state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      drop_r   <= 1'b0;
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      drop_r  <= drop_nx_s;
      if (redirect)    pc_r <= redirect_pc;
      else if (push_s) pc_r <= pc_r + AWIDTH'(1);
      if (redirect)        halted_r <= 1'b0;
      else if (halt_hit_s) halted_r <= 1'b1;
    end
  end

  // FIFO storage, pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= '0;
        pc_mem_r[i]   <= '0;
      end
    end else begin
      count_r <= count_nx_s;
      if (redirect) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
      end else begin
        if (push_s) begin
          data_mem_r[wr_ptr_r] <= rom_data;
          pc_mem_r[wr_ptr_r]   <= pc_r;
          wr_ptr_r             <= wr_ptr_r + PW'(1);
        end
        if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a cycle-timing vector table, directed
// fill/wrap/halt sequences and a random phase, all watched by a queue-based
// reference model of the fetch/decode contract.
module tb_ifetch_queue;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int DEPTH = 4;
  localparam logic [DW-1:0] HALT_OP = 16'hF000;

  logic clk = 1'b0;
  logic rst_n, en_in, rom_ready, rom_valid, redirect, ins_valid, ins_ready, halted;
  logic [AW-1:0] rom_addr, redirect_pc, ins_pc;
  logic [DW-1:0] rom_data, ins;

  always #5 clk = ~clk;

  ifetch_queue #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .RESET_PC(12'h000),
                 .HALT_OP(HALT_OP)) dut (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .rom_ready(rom_ready),
    .rom_addr(rom_addr), .rom_valid(rom_valid), .rom_data(rom_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc), .halted(halted));

  int checks = 0;
  int errors = 0;
  int cyc;

  // irom model: pending responses with their due cycle
  typedef struct { int due; logic [AW-1:0] addr; } rsp_t;
  rsp_t rsp_q[$];
  int lat_min, lat_max;
  logic halt_inject;
  logic [AW-1:0] halt_addr;

  // reference model
  typedef struct packed { logic [DW-1:0] d; logic [AW-1:0] a; } ent_t;
  ent_t mq[$];
  logic [AW-1:0] m_pc, m_req;
  bit m_out, m_drop, m_halted;
  int n_req;
  logic [AW-1:0] req_log[$];
  logic [AW-1:0] pop_log[$];

  // stimulus for the current cycle
  logic s_en, s_ready, s_redir;
  logic [AW-1:0] s_rpc;

  typedef struct {
    logic en, rdy, redir; logic [AW-1:0] rpc;
    logic rr; logic [AW-1:0] ra; logic iv; logic [AW-1:0] ip;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    if (halt_inject && a == halt_addr) return HALT_OP;
    return DW'(a) + 16'h0100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en_in = 1'b0; ins_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; rom_valid = 1'b0; rom_data = '0;
    s_en = 1'b0; s_ready = 1'b0; s_redir = 1'b0; s_rpc = '0;
    rsp_q.delete(); mq.delete(); req_log.delete(); pop_log.delete();
    m_pc = '0; m_req = '0; m_out = 0; m_drop = 0; m_halted = 0; n_req = 0;
    halt_inject = 1'b0; halt_addr = '0; lat_min = 2; lat_max = 2; cyc = 0;
    repeat (2) @(negedge clk);
    chk("rst_rom_ready", rom_ready, 1'b0);
    chk("rst_rom_addr", rom_addr, 12'h000);
    chk("rst_ins_valid", ins_valid, 1'b0);
    chk("rst_ins", ins, 16'h0000);
    chk("rst_ins_pc", ins_pc, 12'h000);
    chk("rst_halted", halted, 1'b0);
    rst_n = 1'b1;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    int lat;
    rsp_t r;
    en_in = s_en; ins_ready = s_ready; redirect = s_redir; redirect_pc = s_rpc;
    rom_valid = 1'b0; rom_data = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      rom_valid = 1'b1;
      rom_data  = rom_word(rsp_q[0].addr);
      void'(rsp_q.pop_front());
    end
    // contract checks against the model
    if (rom_ready) begin
      chk("req_addr", rom_addr, m_pc);
      chk("req_single", m_out, 1'b0);
      chk("req_space", mq.size() < DEPTH, 1'b1);
      chk("req_while_halted", m_halted, 1'b0);
    end
    chk("ins_valid", ins_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("ins", ins, mq[0].d);
      chk("ins_pc", ins_pc, mq[0].a);
    end
    chk("halted", halted, m_halted);
    // irom accepts the request
    if (rom_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      r.due = cyc + lat; r.addr = rom_addr;
      rsp_q.push_back(r);
      n_req++;
      req_log.push_back(rom_addr);
    end
    // model advance
    if (s_redir) begin
      mq.delete();
      m_pc = s_rpc;
      m_halted = 0;
      if (rom_ready) begin m_out = 1; m_drop = 1; m_req = rom_addr; end
      else if (m_out && rom_valid) begin m_out = 0; m_drop = 0; end
      else if (m_out) m_drop = 1;
    end else begin
      if (s_ready && mq.size() > 0) begin
        pop_log.push_back(mq[0].a);
        void'(mq.pop_front());
      end
      if (rom_valid && m_out) begin
        if (!m_drop) begin
          mq.push_back({rom_data, m_req});
          m_pc = m_req + 12'h001;
`ifdef IFETCH_HALT_EN
          if (rom_data == HALT_OP) m_halted = 1;
`endif
        end
        m_out = 0; m_drop = 0;
      end
      if (rom_ready) begin m_out = 1; m_drop = 0; m_req = rom_addr; end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int start;
    // ---- timing table: fetch pacing, decode latency, redirect in WAIT ----
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 1'b0, 12'h000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h001, 1'b1, 12'h000};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h002, 1'b1, 12'h001};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 12'h080, 1'b0, 12'h000, 1'b0, 12'h000};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h080, 1'b0, 12'h000};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h081, 1'b1, 12'h080};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 14; i++) begin
      s_en = tbl[i].en; s_ready = tbl[i].rdy; s_redir = tbl[i].redir; s_rpc = tbl[i].rpc;
      chk("t_rom_ready", rom_ready, tbl[i].rr);
      if (tbl[i].rr) chk("t_rom_addr", rom_addr, tbl[i].ra);
      chk("t_ins_valid", ins_valid, tbl[i].iv);
      if (tbl[i].iv) chk("t_ins_pc", ins_pc, tbl[i].ip);
      step();
    end
    s_redir = 1'b0;

    // ---- fill with decode stalled, then drain and resume ----
    do_reset();
    s_en = 1'b1; s_ready = 1'b0;
    repeat (40) step();
    chk("fill_req_count", n_req, 4);
    for (int i = 0; i < 4; i++) chk("fill_req_addr", req_log[i], 12'(i));
    s_ready = 1'b1;
    for (int k = 0; k < 30 && (pop_log.size() < 4 || n_req < 5); k++) step();
    chk("drain_pops", pop_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("drain_order", pop_log[i], 12'(i));
    chk("resume_req", n_req >= 5, 1'b1);
    if (n_req >= 5) chk("resume_addr", req_log[4], 12'h004);

    // ---- PC wrap via redirect to 12'hFFE ----
    do_reset();
    s_en = 1'b1; s_ready = 1'b1; s_redir = 1'b1; s_rpc = 12'hFFE;
    step();
    s_redir = 1'b0;
    for (int k = 0; k < 60 && pop_log.size() < 4; k++) step();
    chk("wrap_pops", pop_log.size() >= 4, 1'b1);
    if (pop_log.size() >= 4) begin
      chk("wrap_pc0", pop_log[0], 12'hFFE);
      chk("wrap_pc1", pop_log[1], 12'hFFF);
      chk("wrap_pc2", pop_log[2], 12'h000);
      chk("wrap_pc3", pop_log[3], 12'h001);
    end

    // ---- halt opcode at addr 3, then redirect to 12'h010 ----
    do_reset();
    halt_inject = 1'b1; halt_addr = 12'h003;
    s_en = 1'b1; s_ready = 1'b1;
    repeat (40) step();
`ifdef IFETCH_HALT_EN
    chk("halt_req_count", n_req, 4);
    chk("halt_drained", pop_log.size(), 4);
    chk("halt_flag", halted, 1'b1);
`else
    chk("nohalt_continues", n_req > 4, 1'b1);
    chk("nohalt_flag", halted, 1'b0);
`endif
    start = n_req;
    s_redir = 1'b1; s_rpc = 12'h010;
    step();
    s_redir = 1'b0;
    for (int k = 0; k < 20 && n_req <= start + 1; k++) step();
    chk("halt_restart", n_req > start + 1, 1'b1);
    if (n_req > start + 1) chk("halt_restart_addr", req_log[n_req - 1] <= 12'h011 && req_log[n_req - 1] >= 12'h010, 1'b1);
    chk("halt_cleared", halted, 1'b0);

    // ---- random phase ----
    do_reset();
    lat_min = 1; lat_max = 4;
    halt_inject = 1'b1; halt_addr = 12'h0A5;
    for (int k = 0; k < 3000; k++) begin
      s_en    = ($urandom_range(9, 0) != 0);
      s_ready = $urandom_range(1, 0) == 1;
      s_redir = ($urandom_range(31, 0) == 0);
      s_rpc   = ($urandom_range(3, 0) == 0) ? 12'(12'hFFC + 12'($urandom_range(3, 0)))
                                            : 12'($urandom_range(4095, 0));
      step();
    end
    chk("random_progress", pop_log.size() > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
